lcd_scanout_ctrl: RTL and testbench
===================================

Name: lcd_scanout_ctrl

Overview:
Scan-out stage directly downstream of the RGB565 output frame buffer in the CNN display path, running in the TFT pixel-clock domain. Once the upstream converter signals a complete frame, it generates 480x272 LCD timing (HSync/VSync/DE). It reads the buffer's read port in raster order and drives the aligned 5/6/5 RGB pins. It outputs black and idle syncs until a frame is ready.

Parameters:
H_ACTIVE, 480, visible pixels per line
H_FP, 2, horizontal front porch (clocks)
H_SYNC, 41, HSync pulse width (clocks)
H_BP, 2, horizontal back porch (clocks)
V_ACTIVE, 272, visible lines per frame
V_FP, 2, vertical front porch (lines)
V_SYNC, 10, VSync pulse width (lines)
V_BP, 2, vertical back porch (lines)
ADDR_W, 17, frame-buffer address width (must hold H_ACTIVE*V_ACTIVE-1 = 130559)

Ports:
iClk  in  1  TFT pixel clock (12.5 MHz); sole clock
iRsn  in  1  asynchronous active-low reset
iFrameReady  in  1  level; high = buffer holds a complete frame (from converter done)
iRdData  in  16  buffer read data {R5,G6,B5}, valid 1 clock after oRdEn
oRdEn  out  1  buffer read enable
oRdAddr  out  ADDR_W  buffer read address
oLcdHSync  out  1  active-low horizontal sync
oLcdVSync  out  1  active-low vertical sync
oLcdDe  out  1  data enable, high on visible pixels
oLcdR  out  5  red
oLcdG  out  6  green
oLcdB  out  5  blue
oFrameDone  out  1  one-clock pulse after the last visible pixel of a frame
oBusy  out  1  high while in RUN

Behaviour:
- Reset (async, iRsn=0): state=IDLE, hCnt=vCnt=0, addr=0. oLcdHSync=oLcdVSync=1, oLcdDe=0, RGB=0, oRdEn=0, oRdAddr=0, oFrameDone=0, oBusy=0. All pipeline registers are cleared. Reset mid-frame aborts immediately; there is no resume.
- FSM IDLE -> RUN: iFrameReady sampled 1 in IDLE. On the first RUN clock hCnt=0, vCnt=0, addr=0.
- FSM RUN -> IDLE: at frame end (hCnt=H_TOTAL-1, vCnt=V_TOTAL-1), only if iFrameReady=0. Otherwise the next frame starts seamlessly. Dropping iFrameReady mid-frame never truncates the frame.
- Line timing: H_TOTAL = H_SYNC+H_BP+H_ACTIVE+H_FP = 525.
  - hCnt 0..40: sync
  - hCnt 41..42: back porch
  - hCnt 43..522: active
  - hCnt 523..524: front porch
  - hCnt wraps 524 -> 0 and increments vCnt.
- Frame timing: V_TOTAL = 286.
  - vCnt 0..9: sync
  - vCnt 10..11: back porch
  - vCnt 12..283: active
  - vCnt 284..285: front porch
  - vCnt wraps 285 -> 0.
  - Frame = 150150 clocks.
- Slot T (counters = h,v):
  - oRdEn = RUN & hActive & vActive, decoded combinationally from registered counters.
  - oRdAddr = addr. addr increments after each read and resets to 0 at frame start. It never exceeds 130559.
- Output alignment (fixed 2-clock latency):
  - Sync and DE decoded at T pass through 2 register stages.
  - RGB is registered from iRdData at T+1, split as R=[15:11], G=[10:5], B=[4:0].
  - All LCD outputs for slot T therefore appear at T+2.
  - RGB is forced to 0 whenever the delayed DE=0.
- oFrameDone: asserted at T+2 of the slot after the last read (addr 130559, i.e. the clock when the delayed DE falls), for exactly 1 clock.
- IDLE: counters frozen at 0, syncs high, DE=0, RGB=0, no reads.

Decomposition:
- Shared package: H/V timing constants, derived H_TOTAL/V_TOTAL, active-window start/end indices, FRAME_PIXELS=130560, FSM state enum {IDLE, RUN}.
- One natural sub-module: lcd_timing_gen (hCnt/vCnt counters plus sync/active decode). The top adds the FSM, address counter, and the 2-stage alignment pipeline.

Test Plan:
- Reset: hold iRsn=0 for 10 clocks with iFrameReady=1 -> syncs=1, DE=0, RGB=0, oRdEn=0, oBusy=0. Release -> oBusy=1 on the next clock.
- Sync timing: after RUN entry (clock 0), oLcdHSync low for clocks 2..42 and high on 43. oLcdVSync low for 10*525=5250 clocks starting at clock 2.
- First pixel: oRdEn first at clock 12*525+43=6343 with oRdAddr=0. The memory model returns addr-derived data 0xF800 -> oLcdDe=1, R=31/G=0/B=0 at clock 6345.
- Full frame: memory model = expected 565 image -> exactly 130560 DE-high clocks, 480 per line. Captured RGB matches the image. Last read addr 130559. oFrameDone single pulse. The second frame starts with addr=0.
- iFrameReady dropped mid-frame (line 100) -> frame completes all 272 lines, then IDLE with syncs high, no further oRdEn.
- Async reset at line 150, pixel 200 -> outputs reach reset values without a clock edge. Re-release with iFrameReady=1 -> restarts from hCnt=vCnt=0, addr=0.

Source files
------------

// File: rtl/lcd_scanout_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// lcd_scanout_ctrl_pkg
// Shared definitions for the LCD scan-out stage: the 480x272 panel timing
// (porches, sync widths), derived line/frame totals, active-window bounds,
// frame size and the scan-out FSM state type.
// Ports: none (package).
// ---------------------------------------------------------------------------
package lcd_scanout_ctrl_pkg;

    localparam int LCD_H_ACTIVE = 480;
    localparam int LCD_H_FP     = 2;
    localparam int LCD_H_SYNC   = 41;
    localparam int LCD_H_BP     = 2;

    localparam int LCD_V_ACTIVE = 272;
    localparam int LCD_V_FP     = 2;
    localparam int LCD_V_SYNC   = 10;
    localparam int LCD_V_BP     = 2;

    localparam int LCD_ADDR_W   = 17;

    // A line/frame starts with the sync pulse, then back porch, active, front porch.
    localparam int LCD_H_TOTAL     = LCD_H_SYNC + LCD_H_BP + LCD_H_ACTIVE + LCD_H_FP;
    localparam int LCD_V_TOTAL     = LCD_V_SYNC + LCD_V_BP + LCD_V_ACTIVE + LCD_V_FP;
    localparam int LCD_H_ACT_START = LCD_H_SYNC + LCD_H_BP;
    localparam int LCD_H_ACT_END   = LCD_H_ACT_START + LCD_H_ACTIVE - 1;
    localparam int LCD_V_ACT_START = LCD_V_SYNC + LCD_V_BP;
    localparam int LCD_V_ACT_END   = LCD_V_ACT_START + LCD_V_ACTIVE - 1;
    localparam int LCD_FRAME_PIXELS = LCD_H_ACTIVE * LCD_V_ACTIVE;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } scan_state_e;

endpackage

// File: rtl/lcd_timing_gen.sv
// ---------------------------------------------------------------------------
// lcd_timing_gen
// Horizontal/vertical position counters for the panel raster plus the
// sync-window and active-window decodes for the current position.
// Ports:
//   clk, rst_n   pixel clock, async active-low reset
//   en           count enable; counters are held at 0 while low
//   h_sync_act   current position lies in the HSync pulse
//   v_sync_act   current position lies in the VSync pulse
//   active       current position is a visible pixel
//   frame_end    current position is the last clock of the frame
// ---------------------------------------------------------------------------
module lcd_timing_gen
    import lcd_scanout_ctrl_pkg::*;
#(
    parameter int H_SYNC   = LCD_H_SYNC,
    parameter int H_BP     = LCD_H_BP,
    parameter int H_ACTIVE = LCD_H_ACTIVE,
    parameter int H_FP     = LCD_H_FP,
    parameter int V_SYNC   = LCD_V_SYNC,
    parameter int V_BP     = LCD_V_BP,
    parameter int V_ACTIVE = LCD_V_ACTIVE,
    parameter int V_FP     = LCD_V_FP
)(
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic h_sync_act,
    output logic v_sync_act,
    output logic active,
    output logic frame_end
);

    localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);

    localparam logic [HW-1:0] H_LAST      = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_SYNC_END  = HW'(H_SYNC);
    localparam logic [HW-1:0] H_ACT_FIRST = HW'(H_SYNC + H_BP);
    localparam logic [HW-1:0] H_ACT_LAST  = HW'(H_SYNC + H_BP + H_ACTIVE - 1);
    localparam logic [VW-1:0] V_LAST      = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_SYNC_END  = VW'(V_SYNC);
    localparam logic [VW-1:0] V_ACT_FIRST = VW'(V_SYNC + V_BP);
    localparam logic [VW-1:0] V_ACT_LAST  = VW'(V_SYNC + V_BP + V_ACTIVE - 1);

    logic [HW-1:0] h_cnt_q, h_cnt_d;
    logic [VW-1:0] v_cnt_q, v_cnt_d;
    logic          h_wrap;

    always_comb begin
        h_wrap  = (h_cnt_q == H_LAST);
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        if (!en) begin
            h_cnt_d = '0;
            v_cnt_d = '0;
        end else if (h_wrap) begin
            h_cnt_d = '0;
            v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + VW'(1);
        end else begin
            h_cnt_d = h_cnt_q + HW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
        end
    end

    assign h_sync_act = (h_cnt_q < H_SYNC_END);
    assign v_sync_act = (v_cnt_q < V_SYNC_END);
    assign active     = (h_cnt_q >= H_ACT_FIRST) && (h_cnt_q <= H_ACT_LAST) &&
                        (v_cnt_q >= V_ACT_FIRST) && (v_cnt_q <= V_ACT_LAST);
    assign frame_end  = h_wrap && (v_cnt_q == V_LAST);

endmodule

// File: rtl/lcd_scanout_ctrl.sv
// ---------------------------------------------------------------------------
// lcd_scanout_ctrl
// Scans a complete RGB565 frame out of the frame buffer in raster order and
// drives TFT HSync/VSync/DE/RGB with a fixed two-clock alignment between the
// raster position and the panel pins. Outputs stay black with idle syncs
// until the upstream converter reports a complete frame.
// Ports:
//   iClk, iRsn       pixel clock, async active-low reset
//   iFrameReady      level, buffer holds a complete frame
//   iRdData          buffer read data {R5,G6,B5}, valid 1 clock after oRdEn
//   oRdEn, oRdAddr   buffer read strobe / address
//   oLcdHSync/VSync  active-low syncs
//   oLcdDe           data enable
//   oLcdR/G/B        pixel colour, 0 outside DE
//   oFrameDone       1-clock pulse when DE falls after the last pixel
//   oBusy            scan-out running
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | no frame; counters at 0, syncs high, no reads
// ST_RUN  | rastering; re-checks iFrameReady only at the last frame clock
// ---------------------------------------------------------------------------
module lcd_scanout_ctrl
    import lcd_scanout_ctrl_pkg::*;
#(
    parameter int H_SYNC   = LCD_H_SYNC,
    parameter int H_BP     = LCD_H_BP,
    parameter int H_ACTIVE = LCD_H_ACTIVE,
    parameter int H_FP     = LCD_H_FP,
    parameter int V_SYNC   = LCD_V_SYNC,
    parameter int V_BP     = LCD_V_BP,
    parameter int V_ACTIVE = LCD_V_ACTIVE,
    parameter int V_FP     = LCD_V_FP,
    parameter int ADDR_W   = LCD_ADDR_W
)(
    input  logic              iClk,
    input  logic              iRsn,
    input  logic              iFrameReady,
    input  logic [15:0]       iRdData,
    output logic              oRdEn,
    output logic [ADDR_W-1:0] oRdAddr,
    output logic              oLcdHSync,
    output logic              oLcdVSync,
    output logic              oLcdDe,
    output logic [4:0]        oLcdR,
    output logic [5:0]        oLcdG,
    output logic [4:0]        oLcdB,
    output logic              oFrameDone,
    output logic              oBusy
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_ACTIVE * V_ACTIVE - 1);

    scan_state_e       state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              run;
    logic              h_sync_act, v_sync_act, active, frame_end;
    logic              rd_en, last_rd;

    // Stage 1 holds the decode of slot T during T+1, stage 2 during T+2.
    logic              hs1_q, hs1_d, hs2_q, hs2_d;
    logic              vs1_q, vs1_d, vs2_q, vs2_d;
    logic              de1_q, de1_d, de2_q, de2_d;
    logic              last1_q, last1_d, last2_q, last2_d;
    logic              done_q, done_d;
    logic [15:0]       rgb_q, rgb_d;

    lcd_timing_gen #(
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP)
    ) u_timing (
        .clk        (iClk),
        .rst_n      (iRsn),
        .en         (run),
        .h_sync_act (h_sync_act),
        .v_sync_act (v_sync_act),
        .active     (active),
        .frame_end  (frame_end)
    );

    assign run     = (state_q == ST_RUN);
    assign rd_en   = run && active;
    assign last_rd = rd_en && (addr_q == LAST_ADDR);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (iFrameReady)               state_d = ST_RUN;
            ST_RUN:  if (frame_end && !iFrameReady) state_d = ST_IDLE;
            default:                                state_d = ST_IDLE;
        endcase

        // Wrapping right after the last pixel keeps addr at 0 for the next frame.
        addr_d = addr_q;
        if (!run)
            addr_d = '0;
        else if (rd_en)
            addr_d = last_rd ? '0 : addr_q + ADDR_W'(1);

        hs1_d   = ~(run & h_sync_act);
        vs1_d   = ~(run & v_sync_act);
        de1_d   = rd_en;
        last1_d = last_rd;
        hs2_d   = hs1_q;
        vs2_d   = vs1_q;
        de2_d   = de1_q;
        last2_d = last1_q;
        // Pulse lands on the slot after the last read, i.e. when delayed DE falls.
        done_d  = last2_q;
        // Read data for slot T arrives during T+1; de1_q is slot T's DE then.
        rgb_d   = de1_q ? iRdData : 16'h0000;
    end

    always_ff @(posedge iClk or negedge iRsn) begin
        if (!iRsn) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            hs1_q   <= 1'b1;
            hs2_q   <= 1'b1;
            vs1_q   <= 1'b1;
            vs2_q   <= 1'b1;
            de1_q   <= 1'b0;
            de2_q   <= 1'b0;
            last1_q <= 1'b0;
            last2_q <= 1'b0;
            done_q  <= 1'b0;
            rgb_q   <= 16'h0000;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            hs1_q   <= hs1_d;
            hs2_q   <= hs2_d;
            vs1_q   <= vs1_d;
            vs2_q   <= vs2_d;
            de1_q   <= de1_d;
            de2_q   <= de2_d;
            last1_q <= last1_d;
            last2_q <= last2_d;
            done_q  <= done_d;
            rgb_q   <= rgb_d;
        end
    end

    assign oRdEn      = rd_en;
    assign oRdAddr    = addr_q;
    assign oLcdHSync  = hs2_q;
    assign oLcdVSync  = vs2_q;
    assign oLcdDe     = de2_q;
    assign oLcdR      = rgb_q[15:11];
    assign oLcdG      = rgb_q[10:5];
    assign oLcdB      = rgb_q[4:0];
    assign oFrameDone = done_q;
    assign oBusy      = run;

endmodule

// File: tb/tb_lcd_scanout_ctrl.sv
// Bench for lcd_scanout_ctrl. A reduced-geometry instance is checked every
// clock against a raster model; a full 480x272 instance pins the real
// timing numbers over the first ~6350 clocks.
module tb_lcd_scanout_ctrl;

    localparam int S_HS = 4, S_HB = 2, S_HA = 16, S_HF = 2;
    localparam int S_VS = 3, S_VB = 2, S_VA = 6,  S_VF = 2;
    localparam int S_AW = 7;
    localparam int S_HT = S_HS + S_HB + S_HA + S_HF;   // 24
    localparam int S_VT = S_VS + S_VB + S_VA + S_VF;   // 13
    localparam int S_FRAME = S_HT * S_VT;              // 312
    localparam int S_PIX = S_HA * S_VA;                // 96

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic fr = 1'b0;

    logic [15:0]     s_rd_data = 16'h0, f_rd_data = 16'h0;
    logic            s_rd_en, s_hs, s_vs, s_de, s_done, s_busy;
    logic [S_AW-1:0] s_rd_addr;
    logic [4:0]      s_r, s_b;
    logic [5:0]      s_g;
    logic            f_rd_en, f_hs, f_vs, f_de, f_done, f_busy;
    logic [16:0]     f_rd_addr;
    logic [4:0]      f_r, f_b;
    logic [5:0]      f_g;

    int checks = 0;
    int failures = 0;

    lcd_scanout_ctrl #(
        .H_SYNC(S_HS), .H_BP(S_HB), .H_ACTIVE(S_HA), .H_FP(S_HF),
        .V_SYNC(S_VS), .V_BP(S_VB), .V_ACTIVE(S_VA), .V_FP(S_VF),
        .ADDR_W(S_AW)
    ) dut_s (
        .iClk(clk), .iRsn(rst_n), .iFrameReady(fr), .iRdData(s_rd_data),
        .oRdEn(s_rd_en), .oRdAddr(s_rd_addr), .oLcdHSync(s_hs), .oLcdVSync(s_vs),
        .oLcdDe(s_de), .oLcdR(s_r), .oLcdG(s_g), .oLcdB(s_b),
        .oFrameDone(s_done), .oBusy(s_busy)
    );

    lcd_scanout_ctrl dut_f (
        .iClk(clk), .iRsn(rst_n), .iFrameReady(fr), .iRdData(f_rd_data),
        .oRdEn(f_rd_en), .oRdAddr(f_rd_addr), .oLcdHSync(f_hs), .oLcdVSync(f_vs),
        .oLcdDe(f_de), .oLcdR(f_r), .oLcdG(f_g), .oLcdB(f_b),
        .oFrameDone(f_done), .oBusy(f_busy)
    );

    initial forever #5 clk = ~clk;

    // Frame-buffer image: address-derived, pixel 0 is pure red.
    function automatic logic [15:0] img(input int a);
        logic [31:0] x;
        x = a * 32'd40503 + 32'h0000F800;
        return x[15:0];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            if (failures <= 40)
                $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_reset_s(input string tag);
        chk({tag, "_s_hs"}, 32'(s_hs), 32'd1);
        chk({tag, "_s_vs"}, 32'(s_vs), 32'd1);
        chk({tag, "_s_de"}, 32'(s_de), 32'd0);
        chk({tag, "_s_rgb"}, 32'({s_r, s_g, s_b}), 32'd0);
        chk({tag, "_s_rden"}, 32'(s_rd_en), 32'd0);
        chk({tag, "_s_addr"}, 32'(s_rd_addr), 32'd0);
        chk({tag, "_s_done"}, 32'(s_done), 32'd0);
        chk({tag, "_s_busy"}, 32'(s_busy), 32'd0);
    endtask

    task automatic chk_reset_f(input string tag);
        chk({tag, "_f_hs"}, 32'(f_hs), 32'd1);
        chk({tag, "_f_vs"}, 32'(f_vs), 32'd1);
        chk({tag, "_f_de"}, 32'(f_de), 32'd0);
        chk({tag, "_f_rgb"}, 32'({f_r, f_g, f_b}), 32'd0);
        chk({tag, "_f_rden"}, 32'(f_rd_en), 32'd0);
        chk({tag, "_f_addr"}, 32'(f_rd_addr), 32'd0);
        chk({tag, "_f_busy"}, 32'(f_busy), 32'd0);
    endtask

    // Buffer read ports: data for a read seen in slot T is presented during T+1.
    initial begin : mem_s
        logic pend;
        logic [S_AW-1:0] a;
        forever begin
            @(negedge clk);
            pend = s_rd_en;
            a = s_rd_addr;
            @(posedge clk);
            #1;
            s_rd_data = pend ? img(int'(a)) : 16'($urandom);
        end
    end

    initial begin : mem_f
        logic pend;
        logic [16:0] a;
        forever begin
            @(negedge clk);
            pend = f_rd_en;
            a = f_rd_addr;
            @(posedge clk);
            #1;
            f_rd_data = pend ? img(int'(a)) : 16'($urandom);
        end
    end

    // Raster model of the reduced instance: position t within the frame gives
    // (h, v); pin outputs are the decodes of two slots ago, done three ago.
    initial begin : model
        bit m_run;
        int m_t;
        bit p_hs[1:3], p_vs[1:3], p_de[1:3], p_last[1:3];
        int p_pix[1:3];
        int h, v, pix;
        bit c_hs, c_vs, c_de, c_last;
        logic [15:0] exp_rgb;
        m_run = 0;
        m_t = 0;
        for (int i = 1; i <= 3; i++) begin
            p_hs[i] = 1; p_vs[i] = 1; p_de[i] = 0; p_last[i] = 0; p_pix[i] = 0;
        end
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_run = 0;
                m_t = 0;
                for (int i = 1; i <= 3; i++) begin
                    p_hs[i] = 1; p_vs[i] = 1; p_de[i] = 0; p_last[i] = 0; p_pix[i] = 0;
                end
                chk_reset_s("m_rst");
            end else begin
                h = m_t % S_HT;
                v = m_t / S_HT;
                c_de = m_run && h >= S_HS + S_HB && h < S_HS + S_HB + S_HA &&
                       v >= S_VS + S_VB && v < S_VS + S_VB + S_VA;
                pix = (v - (S_VS + S_VB)) * S_HA + (h - (S_HS + S_HB));
                c_hs = !(m_run && h < S_HS);
                c_vs = !(m_run && v < S_VS);
                c_last = c_de && pix == S_PIX - 1;
                exp_rgb = p_de[2] ? img(p_pix[2]) : 16'h0000;

                chk("m_rden", 32'(s_rd_en), 32'(c_de));
                if (c_de) chk("m_addr", 32'(s_rd_addr), 32'(pix));
                else if (!m_run) chk("m_addr_idle", 32'(s_rd_addr), 32'd0);
                chk("m_busy", 32'(s_busy), 32'(m_run));
                chk("m_hs", 32'(s_hs), 32'(p_hs[2]));
                chk("m_vs", 32'(s_vs), 32'(p_vs[2]));
                chk("m_de", 32'(s_de), 32'(p_de[2]));
                chk("m_rgb", 32'({s_r, s_g, s_b}), 32'(exp_rgb));
                chk("m_done", 32'(s_done), 32'(p_last[3]));

                for (int i = 3; i >= 2; i--) begin
                    p_hs[i] = p_hs[i-1]; p_vs[i] = p_vs[i-1]; p_de[i] = p_de[i-1];
                    p_last[i] = p_last[i-1]; p_pix[i] = p_pix[i-1];
                end
                p_hs[1] = c_hs; p_vs[1] = c_vs; p_de[1] = c_de;
                p_last[1] = c_last; p_pix[1] = pix;

                if (m_run) begin
                    if (m_t == S_FRAME - 1) begin
                        m_t = 0;
                        m_run = fr;
                    end else begin
                        m_t++;
                    end
                end else if (fr) begin
                    m_run = 1;
                    m_t = 0;
                end
            end
        end
    end

    initial begin : stim
        int hs_low, vs_cnt, vs_first, vs_last, first_rd, first_addr, done_cnt;
        int de_cnt, rd_cnt, done_c, hs_first;

        // ---- full geometry: reset, then pin the real timing ----
        fr = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk_reset_f("rst");
        chk_reset_s("rst");
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("f_busy_after_release", 32'(f_busy), 32'd1);
        chk("s_busy_after_release", 32'(s_busy), 32'd1);

        hs_low = 0; vs_cnt = 0; vs_first = -1; vs_last = -1;
        first_rd = -1; first_addr = -1; done_cnt = 0;
        for (int c = 0; c < 6350; c++) begin
            @(negedge clk);
            if (c == 1)  chk("f_hs_c1", 32'(f_hs), 32'd1);
            if (c == 2)  chk("f_hs_c2", 32'(f_hs), 32'd0);
            if (c == 42) chk("f_hs_c42", 32'(f_hs), 32'd0);
            if (c == 43) chk("f_hs_c43", 32'(f_hs), 32'd1);
            if (c < 525 && !f_hs) hs_low++;
            if (!f_vs) begin
                vs_cnt++;
                if (vs_first < 0) vs_first = c;
                vs_last = c;
            end
            if (f_rd_en && first_rd < 0) begin
                first_rd = c;
                first_addr = int'(f_rd_addr);
            end
            if (f_done) done_cnt++;
            if (c == 6344) chk("f_de_c6344", 32'(f_de), 32'd0);
            if (c == 6345) begin
                chk("f_de_c6345", 32'(f_de), 32'd1);
                chk("f_r_c6345", 32'(f_r), 32'd31);
                chk("f_g_c6345", 32'(f_g), 32'd0);
                chk("f_b_c6345", 32'(f_b), 32'd0);
            end
            @(posedge clk);
            #1;
        end
        chk("f_hs_low_clocks", 32'(hs_low), 32'd41);
        chk("f_vs_low_clocks", 32'(vs_cnt), 32'd5250);
        chk("f_vs_first", 32'(vs_first), 32'd2);
        chk("f_vs_last", 32'(vs_last), 32'd5251);
        chk("f_first_rd", 32'(first_rd), 32'd6343);
        chk("f_first_addr", 32'(first_addr), 32'd0);
        chk("f_no_done", 32'(done_cnt), 32'd0);

        // ---- async reset mid-frame: outputs drop with no clock edge ----
        #1;
        rst_n = 1'b0;
        #1;
        chk_reset_f("async");
        chk_reset_s("async");
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("f_restart_busy", 32'(f_busy), 32'd1);
        chk("f_restart_addr", 32'(f_rd_addr), 32'd0);
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (c == 1) chk("f_restart_hs_c1", 32'(f_hs), 32'd1);
            if (c == 2) chk("f_restart_hs_c2", 32'(f_hs), 32'd0);
            if (c == 2) chk("f_restart_vs_c2", 32'(f_vs), 32'd0);
            @(posedge clk);
            #1;
        end

        // ---- reduced geometry: drop iFrameReady mid-frame, frame completes ----
        #1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        fr = 1'b1;
        @(posedge clk);
        #1;
        de_cnt = 0; rd_cnt = 0; done_cnt = 0; done_c = -1;
        first_rd = -1; first_addr = -1; hs_low = 0; hs_first = -1;
        for (int c = 0; c < 700; c++) begin
            if (c == 50) fr = 1'b0;
            @(negedge clk);
            if (s_de) de_cnt++;
            if (s_rd_en) rd_cnt++;
            if (s_done) begin
                done_cnt++;
                done_c = c;
            end
            if (s_rd_en && first_rd < 0) begin
                first_rd = c;
                first_addr = int'(s_rd_addr);
            end
            if (c < S_HT && !s_hs) begin
                hs_low++;
                if (hs_first < 0) hs_first = c;
            end
            @(posedge clk);
            #1;
        end
        chk("s_de_clocks", 32'(de_cnt), 32'd96);
        chk("s_rd_count", 32'(rd_cnt), 32'd96);
        chk("s_done_count", 32'(done_cnt), 32'd1);
        chk("s_done_clock", 32'(done_c), 32'd264);
        chk("s_first_rd", 32'(first_rd), 32'd126);
        chk("s_first_addr", 32'(first_addr), 32'd0);
        chk("s_hs_low_clocks", 32'(hs_low), 32'd4);
        chk("s_hs_first", 32'(hs_first), 32'd2);
        chk("s_idle_after_drop", 32'(s_busy), 32'd0);

        // ---- random iFrameReady levels with occasional async resets ----
        for (int it = 0; it < 60; it++) begin
            fr = ($urandom_range(0, 3) != 0);
            repeat ($urandom_range(1, 350)) @(posedge clk);
            #1;
            if ($urandom_range(0, 7) == 0) begin
                #1;
                rst_n = 1'b0;
                #1;
                chk_reset_s("rnd_async");
                @(posedge clk);
                #1;
                rst_n = 1'b1;
            end
        end
        fr = 1'b0;
        repeat (5) @(posedge clk);
        #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
